// File: rtl/pipeline_sequencer_if.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer_if
//   Bundles the request/handshake inputs and the stage-control outputs of the
//   pipeline sequencer so that they travel as one port.
//
//   Request side (driven by the control/hazard/MC units):
//     halt_req, mc_start, mc_done, hz_stall, resume
//   Control side (driven by the sequencer):
//     pc_en, s1_en, s1_bubble, s2_en, s3_en, s3_bubble, mc_go,
//     halt_sys, mc_err, state[1:0], stall_cnt[CNT_W-1:0]
//
//   Modports:
//     master - the requesting side: drives requests and observes controls
//     slave  - the sequencer itself: receives requests and drives controls
// ---------------------------------------------------------------------------
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             halt_req;
  logic             mc_start;
  logic             mc_done;
  logic             hz_stall;
  logic             resume;

  logic             pc_en;
  logic             s1_en;
  logic             s1_bubble;
  logic             s2_en;
  logic             s3_en;
  logic             s3_bubble;
  logic             mc_go;
  logic             halt_sys;
  logic             mc_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output halt_req, mc_start, mc_done, hz_stall, resume,
    input  pc_en, s1_en, s1_bubble, s2_en, s3_en, s3_bubble,
           mc_go, halt_sys, mc_err, state, stall_cnt
  );

  modport slave (
    input  halt_req, mc_start, mc_done, hz_stall, resume,
    output pc_en, s1_en, s1_bubble, s2_en, s3_en, s3_bubble,
           mc_go, halt_sys, mc_err, state, stall_cnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//   Central sequencer for the 3-stage pipeline. Owns the PC load enable, the
//   stage flop enables and the bubble inserts. Arbitrates halt requests,
//   multi-cycle ALU ops and load-use stalls (in that priority order), starts
//   the MUL/DIV unit and waits for its done pulse, and drains the pipe
//   before raising halt_sys.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset
//     sif  - pipeline_sequencer_if.slave (requests in, stage controls out)
//
//   Parameters:
//     DRAIN_CYCLES - cycles spent in DRAIN before HALTED
//     MC_TIMEOUT   - max MC_WAIT cycles before mc_err is raised
//     CNT_W        - width of stall_cnt (must match the interface)
//
//   Configuration macro:
//     PIPE_SEQ_PERF_EN - when defined, stall_cnt counts cycles with pc_en=0
//                        outside HALTED (saturating); otherwise it is tied 0.
//
//   Stage controls are combinational from the registered state and the
//   current inputs; state, counters and mc_err are registered.
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int MC_TIMEOUT   = 32,
  parameter int CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_sequencer_if.slave  sif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_e;

  // One counter is shared by DRAIN and MC_WAIT; it only needs to reach
  // the larger terminal value minus one, so it can never wrap first.
  localparam int MAX_CNT = (DRAIN_CYCLES > MC_TIMEOUT) ? DRAIN_CYCLES : MC_TIMEOUT;
  localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] MC_LAST    = CW'(MC_TIMEOUT - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mc_err_q, mc_err_d;

  logic            pc_en;
  logic            s1_en;
  logic            s1_bubble;
  logic            s2_en;
  logic            s3_en;
  logic            s3_bubble;
  logic            mc_go;
  logic            halt_sys;

  // Next-state and control decode. While rst is high every control is held
  // low regardless of the current state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_err_d  = mc_err_q;
    pc_en     = 1'b0;
    s1_en     = 1'b0;
    s1_bubble = 1'b0;
    s2_en     = 1'b0;
    s3_en     = 1'b0;
    s3_bubble = 1'b0;
    mc_go     = 1'b0;
    halt_sys  = 1'b0;

    if (!rst) begin
      unique case (state_q)
        RUN: begin
          pc_en = 1'b1;
          s1_en = 1'b1;
          s2_en = 1'b1;
          s3_en = 1'b1;
          if (sif.halt_req) begin
            // Freeze PC on the halt and let the older stages retire.
            pc_en     = 1'b0;
            s1_bubble = 1'b1;
            state_d   = DRAIN;
            cnt_d     = '0;
          end else if (sif.mc_start) begin
            // Hold stages 1-2 while the MC unit works; stage 3 gets NOPs.
            mc_go     = 1'b1;
            pc_en     = 1'b0;
            s1_en     = 1'b0;
            s2_en     = 1'b0;
            s3_bubble = 1'b1;
            state_d   = MC_WAIT;
            cnt_d     = '0;
          end else if (sif.hz_stall) begin
            pc_en     = 1'b0;
            s1_bubble = 1'b1;
          end
        end

        MC_WAIT: begin
          s3_en     = 1'b1;
          s3_bubble = 1'b1;
          // A done pulse on the timeout cycle still counts as success.
          if (sif.mc_done) begin
            s2_en   = 1'b1;
            state_d = RUN;
          end else if (cnt_q == MC_LAST) begin
            mc_err_d = 1'b1;
            state_d  = HALTED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        DRAIN: begin
          s1_en     = 1'b1;
          s1_bubble = 1'b1;
          s2_en     = 1'b1;
          s3_en     = 1'b1;
          if (cnt_q == DRAIN_LAST) begin
            state_d = HALTED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        HALTED: begin
          halt_sys = 1'b1;
          if (sif.resume) begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  // State, shared counter and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      mc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mc_err_q <= mc_err_d;
    end
  end

`ifdef PIPE_SEQ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Lost-cycle counter: any non-halted cycle where the PC did not advance.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (state_q != HALTED) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sif.stall_cnt = stall_cnt_q;
`else
  assign sif.stall_cnt = '0;
`endif

  assign sif.pc_en     = pc_en;
  assign sif.s1_en     = s1_en;
  assign sif.s1_bubble = s1_bubble;
  assign sif.s2_en     = s2_en;
  assign sif.s3_en     = s3_en;
  assign sif.s3_bubble = s3_bubble;
  assign sif.mc_go     = mc_go;
  assign sif.halt_sys  = halt_sys;
  assign sif.mc_err    = mc_err_q;
  assign sif.state     = state_q;

endmodule
